// File: rtl/chacha20_poly1305_seq.sv
// Job sequencer mastering the ChaCha20-Poly1305 register bus: loads key/nonce/mode,
// issues init/next/done commands, streams data blocks and returns the final tag.
module chacha20_poly1305_seq #(
  parameter int POLL_LIMIT = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         job_start,
  input  logic         job_encdec,
  input  logic [255:0] job_key,
  input  logic [95:0]  job_nonce,
  input  logic [7:0]   job_nblocks,
  output logic         job_busy,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] out_data,
  output logic         tag_valid,
  output logic [127:0] tag,
  output logic         tag_ok,
  output logic         job_error,
  output logic         bus_cs,
  output logic         bus_we,
  output logic [7:0]   bus_address,
  output logic [511:0] bus_write_data,
  input  logic [511:0] bus_read_data
);

  localparam int PW = $clog2(POLL_LIMIT + 1);

  typedef enum logic [3:0] {
    IDLE, LOAD_KEY, LOAD_NONCE, LOAD_MODE, CMD, POLL_RDY, WAIT_IN, WR_DATA,
    POLL_VAL, RD_DATA, OUT_HOLD, POLL_RDY2, RD_TAG, RD_STAT, ERR
  } state_t;

  typedef enum logic [1:0] {CMD_INIT, CMD_NEXT, CMD_DONE} cmd_t;

  typedef struct packed {
    logic         cs;
    logic         we;
    logic [7:0]   addr;
    logic [511:0] data;
  } bus_t;

  localparam bus_t BUS_IDLE = {1'b0, 1'b0, 8'h00, 512'd0};

  function automatic bus_t bus_wr(input logic [7:0] a, input logic [31:0] d);
    bus_wr = {1'b1, 1'b1, a, 480'd0, d};
  endfunction

  function automatic bus_t bus_rd(input logic [7:0] a);
    bus_rd = {1'b1, 1'b0, a, 512'd0};
  endfunction

  state_t         state_r;
  cmd_t           cmd_r;
  bus_t           bus_r;
  logic [255:0]   key_r;
  logic [95:0]    nonce_r;
  logic           mode_r;
  logic [7:0]     blk_r;
  logic [2:0]     idx_r;
  logic [1:0]     rph_r;
  logic [PW-1:0]  poll_cnt_r;
  logic           is_poll_s;
  logic           poll_ok_s;
  logic           poll_last_s;

  assign bus_cs         = bus_r.cs;
  assign bus_we         = bus_r.we;
  assign bus_address    = bus_r.addr;
  assign bus_write_data = bus_r.data;

  // Success condition of the status poll currently in flight
  always_comb begin
    is_poll_s   = 1'b0;
    poll_ok_s   = bus_read_data[0];
    poll_last_s = (poll_cnt_r == PW'(POLL_LIMIT - 1));
    case (state_r)
      POLL_RDY:  is_poll_s = 1'b1;
      POLL_RDY2: is_poll_s = 1'b1;
      POLL_VAL: begin
        is_poll_s = 1'b1;
        poll_ok_s = &bus_read_data[1:0];
      end
      default:   is_poll_s = 1'b0;
    endcase
  end

  // Job sequencer with registered bus and stream outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r    <= IDLE;
      cmd_r      <= CMD_INIT;
      bus_r      <= BUS_IDLE;
      key_r      <= 256'd0;
      nonce_r    <= 96'd0;
      mode_r     <= 1'b0;
      blk_r      <= 8'd0;
      idx_r      <= 3'd0;
      rph_r      <= 2'd0;
      poll_cnt_r <= {PW{1'b0}};
      job_busy   <= 1'b0;
      in_ready   <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 512'd0;
      tag_valid  <= 1'b0;
      tag        <= 128'd0;
      tag_ok     <= 1'b0;
      job_error  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          tag_valid <= 1'b0;
          job_error <= 1'b0;
          if (job_start) begin
            key_r    <= {job_key[223:0], 32'd0};
            nonce_r  <= job_nonce;
            mode_r   <= job_encdec;
            blk_r    <= job_nblocks;
            idx_r    <= 3'd0;
            bus_r    <= bus_wr(8'h10, job_key[255:224]);
            job_busy <= 1'b1;
            state_r  <= LOAD_KEY;
          end
        end
        // key_r/nonce_r shift so the next word to send is always at the same slice
        LOAD_KEY: begin
          if (idx_r == 3'd7) begin
            bus_r   <= bus_wr(8'h20, nonce_r[31:0]);
            nonce_r <= {32'd0, nonce_r[95:32]};
            idx_r   <= 3'd0;
            state_r <= LOAD_NONCE;
          end else begin
            bus_r <= bus_wr(8'h11 + {5'd0, idx_r}, key_r[255:224]);
            key_r <= {key_r[223:0], 32'd0};
            idx_r <= idx_r + 3'd1;
          end
        end
        LOAD_NONCE: begin
          if (idx_r == 3'd2) begin
            bus_r   <= bus_wr(8'h0a, {31'd0, mode_r});
            state_r <= LOAD_MODE;
          end else begin
            bus_r   <= bus_wr(8'h21 + {5'd0, idx_r}, nonce_r[31:0]);
            nonce_r <= {32'd0, nonce_r[95:32]};
            idx_r   <= idx_r + 3'd1;
          end
        end
        LOAD_MODE: begin
          bus_r   <= bus_wr(8'h08, 32'd1);
          cmd_r   <= CMD_INIT;
          idx_r   <= 3'd0;
          state_r <= CMD;
        end
        // Control register is level-held: every command is followed by a clear
        CMD: begin
          if (idx_r == 3'd0) begin
            bus_r <= bus_wr(8'h08, 32'd0);
            idx_r <= 3'd1;
          end else begin
            poll_cnt_r <= {PW{1'b0}};
            rph_r      <= 2'd0;
            bus_r      <= bus_rd(8'h09);
            case (cmd_r)
              CMD_INIT: state_r <= POLL_RDY;
              CMD_NEXT: state_r <= POLL_VAL;
              CMD_DONE: state_r <= POLL_RDY2;
              default: begin
                bus_r   <= bus_wr(8'h08, 32'd0);
                state_r <= ERR;
              end
            endcase
          end
        end
        // Reads: R1/R2 drive the address, R3 idles the bus and captures the data
        POLL_RDY, POLL_VAL, POLL_RDY2, RD_DATA, RD_TAG, RD_STAT: begin
          if (rph_r == 2'd0) begin
            rph_r <= 2'd1;
          end else if (rph_r == 2'd1) begin
            rph_r <= 2'd2;
            bus_r <= BUS_IDLE;
          end else begin
            rph_r <= 2'd0;
            if (is_poll_s && !poll_ok_s) begin
              if (poll_last_s) begin
                bus_r   <= bus_wr(8'h08, 32'd0);
                state_r <= ERR;
              end else begin
                poll_cnt_r <= poll_cnt_r + PW'(1);
                bus_r      <= bus_rd(8'h09);
              end
            end else begin
              case (state_r)
                POLL_RDY: begin
                  if (blk_r != 8'd0) begin
                    in_ready <= 1'b1;
                    state_r  <= WAIT_IN;
                  end else begin
                    bus_r   <= bus_wr(8'h08, 32'd4);
                    cmd_r   <= CMD_DONE;
                    idx_r   <= 3'd0;
                    state_r <= CMD;
                  end
                end
                POLL_VAL: begin
                  bus_r   <= bus_rd(8'h30);
                  state_r <= RD_DATA;
                end
                POLL_RDY2: begin
                  bus_r   <= bus_rd(8'h40);
                  state_r <= RD_TAG;
                end
                RD_DATA: begin
                  out_data  <= bus_read_data;
                  out_valid <= 1'b1;
                  state_r   <= OUT_HOLD;
                end
                RD_TAG: begin
                  tag     <= bus_read_data[127:0];
                  bus_r   <= bus_rd(8'h09);
                  state_r <= RD_STAT;
                end
                RD_STAT: begin
                  tag_ok    <= bus_read_data[2];
                  tag_valid <= 1'b1;
                  job_busy  <= 1'b0;
                  state_r   <= IDLE;
                end
                default: state_r <= ERR;
              endcase
            end
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            bus_r    <= {1'b1, 1'b1, 8'h30, in_data};
            state_r  <= WR_DATA;
          end
        end
        WR_DATA: begin
          bus_r   <= bus_wr(8'h08, 32'd2);
          cmd_r   <= CMD_NEXT;
          idx_r   <= 3'd0;
          state_r <= CMD;
        end
        OUT_HOLD: begin
          if (out_ready) begin
            out_valid  <= 1'b0;
            blk_r      <= blk_r - 8'd1;
            poll_cnt_r <= {PW{1'b0}};
            rph_r      <= 2'd0;
            bus_r      <= bus_rd(8'h09);
            state_r    <= POLL_RDY;
          end
        end
        ERR: begin
          bus_r     <= BUS_IDLE;
          job_error <= 1'b1;
          job_busy  <= 1'b0;
          state_r   <= IDLE;
        end
        default: begin
          bus_r    <= BUS_IDLE;
          in_ready <= 1'b0;
          job_busy <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_seq.sv
// Directed bench for chacha20_poly1305_seq with a 2-stage-latency register bus model.
module tb_chacha20_poly1305_seq;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         job_start, job_encdec, job_busy;
  logic [255:0] job_key;
  logic [95:0]  job_nonce;
  logic [7:0]   job_nblocks;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [511:0] in_data, out_data;
  logic         tag_valid, tag_ok, job_error;
  logic [127:0] tag;
  logic         bus_cs, bus_we;
  logic [7:0]   bus_address;
  logic [511:0] bus_write_data, bus_read_data;

  localparam logic [255:0] KEY   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [95:0]  NONCE = {32'h09000000, 32'h00000000, 32'h4a000000};
  localparam logic [127:0] TAGV  = 128'h0123456789abcdeffedcba9876543210;
  localparam logic [511:0] MASK  = {16{32'ha5a5a5a5}};

  always #5 clk = ~clk;

  chacha20_poly1305_seq #(.POLL_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .job_start(job_start), .job_encdec(job_encdec), .job_key(job_key),
    .job_nonce(job_nonce), .job_nblocks(job_nblocks), .job_busy(job_busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .tag_valid(tag_valid), .tag(tag), .tag_ok(tag_ok), .job_error(job_error),
    .bus_cs(bus_cs), .bus_we(bus_we), .bus_address(bus_address),
    .bus_write_data(bus_write_data), .bus_read_data(bus_read_data)
  );

  // Register bus model: read data appears two cycles after the address cycle
  logic [2:0]   stat = 3'b111;
  logic [511:0] last30 = 512'd0, s1 = 512'd0, s2 = 512'd0;

  function automatic logic [511:0] bus_val(input logic [7:0] a);
    case (a)
      8'h09:   return {509'd0, stat};
      8'h30:   return last30 ^ MASK;
      8'h40:   return {384'd0, TAGV};
      default: return {504'd0, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (bus_cs && bus_we && bus_address == 8'h30) last30 <= bus_write_data;
    s1 <= (bus_cs && !bus_we) ? bus_val(bus_address) : 512'd0;
    s2 <= s1;
  end
  assign bus_read_data = s2;

  // Monitor of bus, stream and completion activity
  int           cyc = 0;
  logic [7:0]   wa_q[$];
  logic [31:0]  wd_q[$];
  logic [7:0]   ra_q[$];
  int           rc_q[$];
  logic [511:0] out_q[$];
  int           tv_cnt = 0, err_cnt = 0;
  logic         prev_rd = 1'b0;
  logic [127:0] tag_seen = 128'd0;
  logic         tag_ok_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus_cs && bus_we) begin
      wa_q.push_back(bus_address);
      wd_q.push_back(bus_write_data[31:0]);
    end
    if (bus_cs && !bus_we && !prev_rd) begin
      ra_q.push_back(bus_address);
      rc_q.push_back(cyc);
    end
    prev_rd <= bus_cs && !bus_we;
    if (out_valid && out_ready) out_q.push_back(out_data);
    if (tag_valid) begin
      tv_cnt      <= tv_cnt + 1;
      tag_seen    <= tag;
      tag_ok_seen <= tag_ok;
    end
    if (job_error) err_cnt <= err_cnt + 1;
  end

  int   n_run = 0, n_fail = 0;
  int   start_cyc, blk_idx;
  int   wa0, ra0, oq0, tv0, er0;
  logic busy_end;
  logic [39:0] exp_w[16];

  task automatic check(input string name, input logic [511:0] got, input logic [511:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [511:0] blkdata(input int i);
    return {16{32'h11110000 + 32'(i)}};
  endfunction

  task automatic mark();
    wa0 = wa_q.size(); ra0 = ra_q.size(); oq0 = out_q.size();
    tv0 = tv_cnt; er0 = err_cnt;
  endtask

  task automatic start_job(input logic [7:0] nb, input logic ed);
    @(negedge clk);
    job_key = KEY; job_nonce = NONCE; job_nblocks = nb; job_encdec = ed;
    job_start = 1'b1; start_cyc = cyc;
    @(negedge clk);
    job_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int maxc);
    logic ok, hs;
    ok = 1'b0; hs = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (hs) begin
        blk_idx++;
        in_data = blkdata(blk_idx);
      end
      hs = in_valid && in_ready;
      if (tag_valid || job_error) begin
        ok = 1'b1;
        busy_end = job_busy;
        break;
      end
    end
    check(name, {511'd0, ok}, 512'd1);
    @(negedge clk);
  endtask

  initial begin
    int n_cmd;
    logic ok;
    reset_n = 1'b0; job_start = 1'b0; job_encdec = 1'b0; job_key = 256'd0;
    job_nonce = 96'd0; job_nblocks = 8'd0; in_valid = 1'b0; in_data = 512'd0;
    out_ready = 1'b0; blk_idx = 0; busy_end = 1'b0;
    for (int i = 0; i < 8; i++) exp_w[i] = {8'h10 + 8'(i), 32'h00010203 + 32'(i) * 32'h04040404};
    exp_w[8]  = {8'h20, 32'h4a000000}; exp_w[9]  = {8'h21, 32'h00000000};
    exp_w[10] = {8'h22, 32'h09000000}; exp_w[11] = {8'h0a, 32'h00000000};
    exp_w[12] = {8'h08, 32'h1}; exp_w[13] = {8'h08, 32'h0};
    exp_w[14] = {8'h08, 32'h4}; exp_w[15] = {8'h08, 32'h0};
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {bus_cs, bus_we, bus_address, bus_write_data, in_ready, out_valid,
          out_data, tag_valid, tag, tag_ok, job_error}, 512'd0);
    check("reset_busy", {511'd0, job_busy}, 512'd0);

    // Tag-only job: setup write order, read sequence and tag
    stat = 3'b111; mark();
    start_job(8'd0, 1'b0);
    wait_done("t1_done", 300);
    check("t1_busy_at_tag", {511'd0, busy_end}, 512'd0);
    check("t1_tag_1cyc", {511'd0, tag_valid}, 512'd0);
    check("t1_nwrites", wa_q.size() - wa0, 16);
    if (wa_q.size() - wa0 >= 16)
      for (int i = 0; i < 16; i++)
        check($sformatf("t1_write%0d", i), {wa_q[wa0+i], wd_q[wa0+i]}, exp_w[i]);
    check("t1_nreads", ra_q.size() - ra0, 4);
    if (ra_q.size() - ra0 >= 4) begin
      check("t1_read_addrs", {ra_q[ra0], ra_q[ra0+1], ra_q[ra0+2], ra_q[ra0+3]}, 32'h09094009);
      check("t1_first_poll_lat", rc_q[ra0] - start_cyc, 15);
    end
    check("t1_tag", tag_seen, TAGV);
    check("t1_tag_ok", {511'd0, tag_ok_seen}, 512'd1);
    check("t1_pulses", {tv_cnt - tv0, err_cnt - er0}, {32'd1, 32'd0});

    // Two-block encrypt with streams always ready
    mark(); blk_idx = 0; in_data = blkdata(0); in_valid = 1'b1; out_ready = 1'b1;
    start_job(8'd2, 1'b1);
    wait_done("t2_done", 500);
    in_valid = 1'b0;
    check("t2_nout", out_q.size() - oq0, 2);
    if (out_q.size() - oq0 >= 2) begin
      check("t2_out0", out_q[oq0], blkdata(0) ^ MASK);
      check("t2_out1", out_q[oq0+1], blkdata(1) ^ MASK);
    end
    check("t2_mode", {wa_q[wa0+11], wd_q[wa0+11]}, {8'h0a, 32'h1});
    n_cmd = 0;
    for (int i = wa0; i < wa_q.size() - 1; i++)
      if (wa_q[i] == 8'h08 && wd_q[i] != 32'h0) begin
        n_cmd++;
        check("t2_cmd_clear", {wa_q[i+1], wd_q[i+1]}, {8'h08, 32'h0});
      end
    check("t2_ncmd", n_cmd, 4);
    check("t2_in_ready_idle", {511'd0, in_ready}, 512'd0);
    check("t2_pulses", {tv_cnt - tv0, err_cnt - er0}, {32'd1, 32'd0});

    // Poll timeout: bus never ready
    stat = 3'b000; mark();
    start_job(8'd0, 1'b0);
    wait_done("t3_done", 300);
    check("t3_busy_at_err", {511'd0, busy_end}, 512'd0);
    check("t3_nreads", ra_q.size() - ra0, 4);
    for (int i = ra0; i < ra_q.size(); i++) check("t3_read_addr", ra_q[i], 8'h09);
    check("t3_nwrites", wa_q.size() - wa0, 15);
    check("t3_last_write", {wa_q[wa_q.size()-1], wd_q[wd_q.size()-1]}, {8'h08, 32'h0});
    check("t3_pulses", {tv_cnt - tv0, err_cnt - er0}, {32'd0, 32'd1});
    stat = 3'b111;

    // Output back-pressure: data held, bus quiet, job_start ignored
    mark(); blk_idx = 0; in_data = blkdata(0); in_valid = 1'b1; out_ready = 1'b0;
    start_job(8'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    in_valid = 1'b0;
    check("t4_out_valid_seen", {511'd0, ok}, 512'd1);
    check("t4_out_data", out_data, blkdata(0) ^ MASK);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      job_start = (i == 3);
      check("t4_hold", {bus_cs, out_valid, out_data}, {1'b0, 1'b1, blkdata(0) ^ MASK});
    end
    job_start = 1'b0;
    out_ready = 1'b1;
    wait_done("t4_done", 300);
    mark();
    repeat (30) @(negedge clk);
    check("t4_start_ignored", {job_busy, 32'(wa_q.size() - wa0)}, 33'd0);
    check("t4_single_tag", tv_cnt, tv0);

    // tag_ok clear: tag must still come from 0x40, tag_ok from status bit2
    stat = 3'b011; mark();
    start_job(8'd0, 1'b0);
    wait_done("t5_done", 300);
    check("t5_tag", tag_seen, TAGV);
    check("t5_tag_ok", {511'd0, tag_ok_seen}, 512'd0);
    stat = 3'b111;

    // Reset during NEXT, then a clean job
    mark(); blk_idx = 0; in_data = blkdata(0); in_valid = 1'b1; out_ready = 1'b1;
    start_job(8'd1, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge clk);
      ok = bus_cs && bus_we && bus_address == 8'h08 && bus_write_data[31:0] == 32'd2;
    end
    check("t6_next_seen", {511'd0, ok}, 512'd1);
    reset_n = 1'b0;
    #1;
    check("t6_reset_outputs", {bus_cs, bus_we, bus_address, in_ready, out_valid, tag_valid,
          job_error, job_busy}, 512'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_pulse", {tv_cnt - tv0, err_cnt - er0}, 64'd0);
    mark(); blk_idx = 0; in_data = blkdata(0);
    start_job(8'd1, 1'b0);
    wait_done("t6_done", 400);
    in_valid = 1'b0;
    check("t6_pulses", {tv_cnt - tv0, err_cnt - er0}, {32'd1, 32'd0});
    check("t6_nout", out_q.size() - oq0, 1);
    if (out_q.size() > oq0) check("t6_out0", out_q[oq0], blkdata(0) ^ MASK);
    check("t6_tag", tag_seen, TAGV);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
